// File: rtl/systolic_gemm_tile.sv
// systolic_gemm_tile: output-stationary ROWS x COLS systolic GEMM tile.
// Operands enter one k-beat per handshake. Row r of A is delayed r cycles and
// column c of B is delayed c cycles, so beat k meets in PE(r,c) in one cycle.
// After k_len beats and a flush of ROWS+COLS-1 cycles, rows drain one per
// output handshake.
// Optional build macro SYSTOLIC_SAT_EN: saturating, sticky accumulation.
// Without it, accumulators wrap modulo 2^OUT_WIDTH.
module systolic_gemm_tile #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_MAX     = 256,
  parameter int KW        = $clog2(K_MAX) + 1,
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH*ROWS-1:0]  a_data,
  input  logic [IN_WIDTH*COLS-1:0]  b_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH*COLS-1:0] out_data,
  output logic [RW-1:0]             out_row,
  output logic                      out_last
);

  localparam int PW = 2 * IN_WIDTH;
  localparam int FW = $clog2(ROWS + COLS) + 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t                       state;
  logic [KW-1:0]                k_lat, k_cnt;
  logic [FW-1:0]                fl_cnt;
  logic                         hs, clr;
  logic [RW-1:0]                row_nxt;
  logic [OUT_WIDTH*COLS-1:0]    row_pack;

  logic signed [IN_WIDTH-1:0]   a_w [ROWS];
  logic                         av_w [ROWS];
  logic signed [IN_WIDTH-1:0]   b_w [COLS];
  logic                         bv_w [COLS];
  logic signed [IN_WIDTH-1:0]   a_in [ROWS][COLS];
  logic signed [IN_WIDTH-1:0]   b_in [ROWS][COLS];
  logic                         av_in [ROWS][COLS];
  logic                         bv_in [ROWS][COLS];
  logic signed [IN_WIDTH-1:0]   a_q [ROWS][COLS-1];
  logic                         av_q [ROWS][COLS-1];
  logic signed [IN_WIDTH-1:0]   b_q [ROWS-1][COLS];
  logic                         bv_q [ROWS-1][COLS];
  logic signed [OUT_WIDTH-1:0]  acc [ROWS][COLS];

  // Full-precision product, sign-extended to the accumulator width.
  function automatic logic signed [OUT_WIDTH-1:0] mul_ext(
    input logic signed [IN_WIDTH-1:0] a,
    input logic signed [IN_WIDTH-1:0] b
  );
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return OUT_WIDTH'(p);
  endfunction

`ifdef SYSTOLIC_SAT_EN
  logic sat_q [ROWS][COLS];

  function automatic logic signed [OUT_WIDTH:0] wide_sum(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] p
  );
    return {a[OUT_WIDTH-1], a} + {p[OUT_WIDTH-1], p};
  endfunction

  function automatic logic sum_ovf(input logic signed [OUT_WIDTH:0] s);
    return s[OUT_WIDTH] ^ s[OUT_WIDTH-1];
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_clip(input logic signed [OUT_WIDTH:0] s);
    if (!sum_ovf(s))      return s[OUT_WIDTH-1:0];
    else if (s[OUT_WIDTH]) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                   return {1'b0, {(OUT_WIDTH-1){1'b1}}};
  endfunction
`else
  function automatic logic signed [OUT_WIDTH-1:0] wrap_add(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] p
  );
    return a + p;
  endfunction
`endif

  assign hs      = in_valid & in_ready;
  assign clr     = (state == IDLE) & start & (k_len != '0);
  assign row_nxt = (state == DRAIN) ? out_row + RW'(1) : '0;

  // ---- input skew: row r / column c delayed r / c cycles ----
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [IN_WIDTH-1:0] a_lane;
    assign a_lane = hs ? $signed(a_data[r*IN_WIDTH +: IN_WIDTH]) : '0;
    if (r == 0) begin : g_direct
      assign a_w[r]  = a_lane;
      assign av_w[r] = hs;
    end else begin : g_delay
      logic signed [IN_WIDTH-1:0] dly [r];
      logic                       dly_v [r];
      // Shift line delaying this A lane (and its valid) by r cycles.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < r; s++) begin
            dly[s]   <= '0;
            dly_v[s] <= 1'b0;
          end
        end else begin
          dly[0]   <= a_lane;
          dly_v[0] <= hs;
          for (int s = 1; s < r; s++) begin
            dly[s]   <= dly[s-1];
            dly_v[s] <= dly_v[s-1];
          end
        end
      end
      assign a_w[r]  = dly[r-1];
      assign av_w[r] = dly_v[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [IN_WIDTH-1:0] b_lane;
    assign b_lane = hs ? $signed(b_data[c*IN_WIDTH +: IN_WIDTH]) : '0;
    if (c == 0) begin : g_direct
      assign b_w[c]  = b_lane;
      assign bv_w[c] = hs;
    end else begin : g_delay
      logic signed [IN_WIDTH-1:0] dly [c];
      logic                       dly_v [c];
      // Shift line delaying this B lane (and its valid) by c cycles.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < c; s++) begin
            dly[s]   <= '0;
            dly_v[s] <= 1'b0;
          end
        end else begin
          dly[0]   <= b_lane;
          dly_v[0] <= hs;
          for (int s = 1; s < c; s++) begin
            dly[s]   <= dly[s-1];
            dly_v[s] <= dly_v[s-1];
          end
        end
      end
      assign b_w[c]  = dly[c-1];
      assign bv_w[c] = dly_v[c-1];
    end
  end

  // Route each PE's operands from the skew edge or its left/upper neighbour.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      a_in[r][0]  = a_w[r];
      av_in[r][0] = av_w[r];
      for (int c = 1; c < COLS; c++) begin
        a_in[r][c]  = a_q[r][c-1];
        av_in[r][c] = av_q[r][c-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      b_in[0][c]  = b_w[c];
      bv_in[0][c] = bv_w[c];
      for (int r = 1; r < ROWS; r++) begin
        b_in[r][c]  = b_q[r-1][c];
        bv_in[r][c] = bv_q[r-1][c];
      end
    end
  end

  // ---- PE array: forward operands, accumulate valid pairs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS - 1; c++) begin
          a_q[r][c]  <= '0;
          av_q[r][c] <= 1'b0;
        end
      end
      for (int r = 0; r < ROWS - 1; r++) begin
        for (int c = 0; c < COLS; c++) begin
          b_q[r][c]  <= '0;
          bv_q[r][c] <= 1'b0;
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          acc[r][c] <= '0;
`ifdef SYSTOLIC_SAT_EN
          sat_q[r][c] <= 1'b0;
`endif
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS - 1; c++) begin
          a_q[r][c]  <= a_in[r][c];
          av_q[r][c] <= av_in[r][c];
        end
      end
      for (int r = 0; r < ROWS - 1; r++) begin
        for (int c = 0; c < COLS; c++) begin
          b_q[r][c]  <= b_in[r][c];
          bv_q[r][c] <= bv_in[r][c];
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (clr) begin
            acc[r][c] <= '0;
`ifdef SYSTOLIC_SAT_EN
            sat_q[r][c] <= 1'b0;
          end else if (av_in[r][c] && bv_in[r][c] && !sat_q[r][c]) begin
            acc[r][c]   <= sat_clip(wide_sum(acc[r][c], mul_ext(a_in[r][c], b_in[r][c])));
            sat_q[r][c] <= sum_ovf(wide_sum(acc[r][c], mul_ext(a_in[r][c], b_in[r][c])));
          end
`else
          end else if (av_in[r][c] && bv_in[r][c]) begin
            acc[r][c] <= wrap_add(acc[r][c], mul_ext(a_in[r][c], b_in[r][c]));
          end
`endif
        end
      end
    end
  end

  // Pack the next row to be presented so it can be registered onto out_data.
  always_comb begin
    row_pack = '0;
    for (int c = 0; c < COLS; c++) begin
      row_pack[c*OUT_WIDTH +: OUT_WIDTH] = acc[row_nxt][c];
    end
  end

  // ---- control FSM with registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      k_lat     <= '0;
      k_cnt     <= '0;
      fl_cnt    <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: if (clr) begin
          state    <= LOAD;
          k_lat    <= k_len;
          k_cnt    <= '0;
          busy     <= 1'b1;
          in_ready <= 1'b1;
        end
        LOAD: if (hs) begin
          if (k_cnt + KW'(1) == k_lat) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
            fl_cnt   <= '0;
          end else begin
            k_cnt <= k_cnt + KW'(1);
          end
        end
        FLUSH: if (fl_cnt == FLUSH_LAST) begin
          state     <= DRAIN;
          out_valid <= 1'b1;
          out_row   <= '0;
          out_last  <= (ROWS == 1);
          out_data  <= row_pack;
        end else begin
          fl_cnt <= fl_cnt + FW'(1);
        end
        DRAIN: if (out_ready) begin
          if (out_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_data  <= '0;
          end else begin
            out_row  <= row_nxt;
            out_last <= (row_nxt == RW'(ROWS - 1));
            out_data <= row_pack;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Testbench for systolic_gemm_tile: a 32-bit-accumulator instance plus a
// 16-bit instance sharing all inputs (used for the overflow behaviour).
module tb_systolic_gemm_tile;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int IW   = 8;
  localparam int KW   = 9;
  localparam int KB   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n, start, in_valid, out_ready;
  logic [KW-1:0]        k_len;
  logic [IW*ROWS-1:0]   a_data;
  logic [IW*COLS-1:0]   b_data;
  logic                 busy, in_ready, out_valid, out_last;
  logic [32*COLS-1:0]   out_data;
  logic [1:0]           out_row;
  logic                 busy2, in_ready2, out_valid2, out_last2;
  logic [16*COLS-1:0]   out_data2;
  logic [1:0]           out_row2;

  always #5 clk = ~clk;

  systolic_gemm_tile #(.IN_WIDTH(IW), .OUT_WIDTH(32), .ROWS(ROWS), .COLS(COLS)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last));

  systolic_gemm_tile #(.IN_WIDTH(IW), .OUT_WIDTH(16), .ROWS(ROWS), .COLS(COLS)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy2),
    .in_valid(in_valid), .in_ready(in_ready2), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_row(out_row2), .out_last(out_last2));

  typedef struct packed { int k; int a; int b; bit bub; int exp; } vec_t;
  typedef struct packed { int row; logic last; logic [127:0] d32; logic [63:0] d16; } exp_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_hs = 0;
  int   ma [ROWS][KB];
  int   mb [KB][COLS];
  exp_t sb [$];
  exp_t mon_e;
  vec_t tbl [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference for the 16-bit instance: sequential accumulation, wrap or sticky saturate.
  function automatic logic [15:0] acc16(input int k_end, input int r, input int c);
    int s;
    bit sat;
    s = 0;
    sat = 1'b0;
    for (int k = 0; k < k_end; k++) begin
`ifdef SYSTOLIC_SAT_EN
      if (!sat) begin
        s = s + ma[r][k] * mb[k][c];
        if (s > 32767)       begin s = 32767;  sat = 1'b1; end
        else if (s < -32768) begin s = -32768; sat = 1'b1; end
      end
`else
      s = s + ma[r][k] * mb[k][c];
`endif
    end
    return s[15:0];
  endfunction

  task automatic fill_uniform(input int av, input int bv);
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < KB; k++) ma[r][k] = av;
    for (int k = 0; k < KB; k++) for (int c = 0; c < COLS; c++) mb[k][c] = bv;
  endtask

  task automatic push_rows(input int k, input bit use_tbl, input int tval);
    for (int r = 0; r < ROWS; r++) begin
      exp_t e;
      e.row  = r;
      e.last = (r == ROWS - 1);
      e.d32  = '0;
      e.d16  = '0;
      for (int c = 0; c < COLS; c++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < k; kk++) s = s + ma[r][kk] * mb[kk][c];
        e.d32[c*32 +: 32] = use_tbl ? tval : s;
        e.d16[c*16 +: 16] = acc16(k, r, c);
      end
      sb.push_back(e);
    end
  endtask

  task automatic beat(input int kk);
    int t;
    for (int r = 0; r < ROWS; r++) a_data[r*IW +: IW] = 8'(ma[r][kk]);
    for (int c = 0; c < COLS; c++) b_data[c*IW +: IW] = 8'(mb[kk][c]);
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    last_hs  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int k, input bit bub, input bit use_tbl, input int tval);
    push_rows(k, use_tbl, tval);
    k_len = KW'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int kk = 0; kk < k; kk++) begin
      if (bub && kk > 0) begin @(posedge clk); #1; end
      beat(kk);
    end
    chk("in_ready_drop", in_ready, 0);
  endtask

  // First out_valid must appear ROWS+COLS-1 edges after the last handshake edge.
  task automatic wait_first_valid();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk("latency", cyc - last_hs, ROWS + COLS - 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(out_valid && out_ready && out_last) && t < 200);
    if (t >= 200) chk("drain_timeout", t, 0);
    @(negedge clk);
    chk("busy_after_last", busy, 0);
    chk("out_valid_after_last", out_valid, 0);
  endtask

  // Scoreboard: every accepted output row is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_row", sb.size(), 1);
      else begin
        mon_e = sb.pop_front();
        chk("out_row", out_row, mon_e.row);
        chk("out_last", out_last, mon_e.last);
        chk_vec("out_data", out_data, mon_e.d32);
        chk_vec("out_data16", {64'd0, out_data2}, {64'd0, mon_e.d16});
        chk("out_valid16", out_valid2, 1);
        chk("out_row16", out_row2, mon_e.row);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1,    2,    3, 1'b0,       6};
    tbl[1] = '{3,   -5,    7, 1'b1,    -105};
    tbl[2] = '{3,   -5,    7, 1'b0,    -105};
    tbl[3] = '{8,  127, -128, 1'b0, -130048};
    tbl[4] = '{2,   -1,   -1, 1'b1,       2};

    rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_data = '0; b_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk_vec("rst_out_data", out_data, 128'd0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy16", busy2, 0);
    chk("rst_in_ready16", in_ready2, 0);
    chk("rst_out_last16", out_last2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      fill_uniform(tbl[i].a, tbl[i].b);
      run_job(tbl[i].k, tbl[i].bub, 1'b1, tbl[i].exp);
      wait_first_valid();
      wait_done();
    end

    // Identity A against B[k][c] = 10k + c.
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < KB; k++) ma[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < KB; k++) for (int c = 0; c < COLS; c++) mb[k][c] = 10 * k + c;
    run_job(4, 1'b0, 1'b0, 0);
    wait_first_valid();
    chk_vec("identity_row0", out_data, {32'd3, 32'd2, 32'd1, 32'd0});
    wait_done();

    // Backpressure on row 1.
    fill_uniform(3, 4);
    run_job(2, 1'b0, 1'b1, 24);
    wait_first_valid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_row", out_row, 1);
      chk_vec("stall_data", out_data, {4{32'd24}});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done();

    // Overflow: (-128)*(-128)*4 = 65536.
    fill_uniform(-128, -128);
    run_job(4, 1'b0, 1'b0, 0);
    wait_first_valid();
`ifdef SYSTOLIC_SAT_EN
    chk_vec("ovf16_row0", {64'd0, out_data2}, {64'd0, {4{16'h7fff}}});
`else
    chk_vec("ovf16_row0", {64'd0, out_data2}, 128'd0);
`endif
    wait_done();

    // Reset mid-load, zero-length start, then a clean job.
    fill_uniform(7, 9);
    k_len = KW'(4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beat(0);
    beat(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    k_len = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("klen0_busy", busy, 0);
      chk("klen0_in_ready", in_ready, 0);
    end
    fill_uniform(1, 5);
    run_job(1, 1'b0, 1'b0, 0);
    wait_first_valid();
    chk_vec("post_abort_row0", out_data, {4{32'd5}});
    wait_done();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_gemm_tile.md
Name: systolic_gemm_tile

Overview:
- Parametrised output-stationary systolic GEMM tile with internal operand skew, valid/ready streaming on input and output, a programmable reduction depth, and a row-serial result drain with backpressure.
- Successor to the current MAC array: it removes the external skew and control sequencing, and adds job start/busy and stall-free bubble handling.
- Sits between the operand buffers and the writeback path of the accelerator.

Parameters:
- IN_WIDTH, 8: signed operand width.
- OUT_WIDTH, 32: signed accumulator/output width; must be >= 2*IN_WIDTH.
- ROWS, 4: PE rows, one A operand per row.
- COLS, 4: PE columns, one B operand per column.
- K_MAX, 256: maximum reduction depth per job.
- KW, $clog2(K_MAX)+1: width of k_len.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KW  reduction depth, sampled with start.
- busy  out  1  high whenever the FSM is not in IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  tile accepts a beat.
- a_data  in  IN_WIDTH*ROWS  A column-slice; lane r goes to row r.
- b_data  in  IN_WIDTH*COLS  B row-slice; lane c goes to column c.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the row.
- out_data  out  OUT_WIDTH*COLS  C[out_row][0..COLS-1]; lane c is column c.
- out_row  out  $clog2(ROWS) (min 1)  index of the row being presented.
- out_last  out  1  high with the final row (ROWS-1).

Behaviour:
- Reset (rst_n low at a clk edge): FSM goes to IDLE, all accumulators, skew and valid registers cleared. busy=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0.
- Reset mid-job abandons the job with no residual state.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start=1 and k_len!=0: latch k_len, clear all accumulators and the beat counter, go to LOAD.
  - start with k_len==0: ignored.
  - start in any state other than IDLE: ignored.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) injects a[r] into row r through an r-stage delay and b[c] into column c through a c-stage delay.
  - Each operand carries a valid bit. Cycles without a handshake inject valid=0 bubbles.
  - After exactly k_len handshakes, go to FLUSH; in_ready drops in the cycle after the last handshake.
- PE(r,c):
  - Registers a rightward and b downward each cycle, together with their valid bits.
  - Accumulates a*b only when the incoming valid bit is 1.
  - The skew guarantees that the operand pair with the same k index meets in the same PE cycle.
- FLUSH: wait ROWS+COLS-1 cycles so the last beat reaches PE(ROWS-1,COLS-1), then go to DRAIN.
- DRAIN and output timing:
  - If the last input handshake is at cycle L, out_valid first rises at cycle L+ROWS+COLS.
  - Rows are presented in order 0..ROWS-1; out_row advances only on out_valid & out_ready.
  - out_data, out_row and out_last are held stable while out_valid=1 and out_ready=0.
  - After the handshake on row ROWS-1 (out_last=1): out_valid=0, go to IDLE, busy=0 in the next cycle.
- Arithmetic:
  - Two's-complement.
  - Product is 2*IN_WIDTH bits, sign-extended to OUT_WIDTH.
  - Accumulation wraps modulo 2^OUT_WIDTH (default).
- Throughput: one beat per cycle in LOAD; one row per cycle in DRAIN when out_ready stays high.

Optional Feature:
- Macro SYSTOLIC_SAT_EN.
- Defined: each accumulator add saturates to the signed limits [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Saturation is sticky for that PE until the next job clears it.
- Undefined: accumulation wraps.
- Ports and timing are identical in both builds.

Test Plan:
- Basic drain: defaults, k_len=1, a=all 2, b=all 3 -> rows 0..3 each all 6; out_valid rises at L+8; out_last only with out_row=3; busy=0 after the final handshake.
- Identity: k_len=4, A=identity, B[k][c]=10k+c -> C[r][c]=10r+c for all r,c.
- Bubbles: k_len=3, in_valid toggling 1,0,1,0,1 -> results match the back-to-back case; in_ready falls after the 3rd handshake.
- Backpressure: during DRAIN, out_ready=0 for 5 cycles on row 1 -> row 1 data held, no row skipped or duplicated, order still 0,1,2,3.
- Overflow: IN_WIDTH=8, OUT_WIDTH=16, a=b=-128, k_len=4 -> 0 in every lane without SYSTOLIC_SAT_EN; 32767 with it.
- Reset and start gating: rst_n low for 1 cycle after 2 of 4 LOAD beats, then start with k_len=0 -> busy stays 0; then a k_len=1 job with a=1, b=5 -> all outputs 5, no residue from the aborted job.
